// File: rtl/if_fetch.sv
// if_fetch: RV32I instruction-fetch stage. Assembles each 32-bit instruction
// from four little-endian byte reads on a shared 8-bit memory port. The port
// is yielded to the memory stage whenever mem_busy_i is high. The finished
// word sits in an output buffer that is held while downstream stalls.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        mem_busy_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] mem_a_o,
  output logic        mem_rd_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc;
  logic [2:0]  iss_cnt;
  logic [2:0]  rcv_cnt;
  logic        rd_q;
  logic [31:0] word_q;
  logic [31:0] word_next;
  logic        complete;
  logic        buf_free;

  // A read goes out only while fetching, bytes remain to be issued, and the
  // port is neither owned by the memory stage nor being abandoned by a redirect.
  assign mem_rd_o = (state == FETCH) && (iss_cnt < 3'd4) && !mem_busy_i
                    && !branch_flag_i && !rst;
  assign mem_a_o  = pc + {29'd0, iss_cnt};

  // The word is complete on the edge that captures byte 3.
  assign complete = (state == FETCH) && rd_q && (rcv_cnt == 3'd3);
  assign buf_free = !inst_valid_o || !stall_i;

  // Merge the byte returning this cycle into the partially assembled word.
  always_comb begin
    word_next = word_q;
    if (rd_q) begin
      case (rcv_cnt[1:0])
        2'd0:    word_next[7:0]   = mem_din_i;
        2'd1:    word_next[15:8]  = mem_din_i;
        2'd2:    word_next[23:16] = mem_din_i;
        default: word_next[31:24] = mem_din_i;
      endcase
    end
  end

  // Fetch sequencing, byte capture, output buffer and redirect handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      iss_cnt      <= '0;
      rcv_cnt      <= '0;
      rd_q         <= 1'b0;
      word_q       <= '0;
      pc_o         <= '0;
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
    end else if (branch_flag_i) begin
      // Redirect drops the partial word and any buffered instruction; the
      // byte still in flight from the old stream is ignored via rd_q.
      state        <= FETCH;
      pc           <= branch_target_i;
      iss_cnt      <= '0;
      rcv_cnt      <= '0;
      rd_q         <= 1'b0;
      inst_valid_o <= 1'b0;
    end else begin
      rd_q <= mem_rd_o;
      if (mem_rd_o) begin
        iss_cnt <= iss_cnt + 3'd1;
      end
      if (rd_q) begin
        word_q  <= word_next;
        rcv_cnt <= rcv_cnt + 3'd1;
      end
      if (inst_valid_o && !stall_i) begin
        inst_valid_o <= 1'b0;
      end
      if (state == FETCH) begin
        if (complete) begin
          if (buf_free) begin
            inst_o       <= word_next;
            pc_o         <= pc;
            inst_valid_o <= 1'b1;
            pc           <= pc + 32'd4;
            iss_cnt      <= '0;
            rcv_cnt      <= '0;
          end else begin
            state <= HOLD;
          end
        end
      end else begin
        if (!stall_i) begin
          inst_o       <= word_q;
          pc_o         <= pc;
          inst_valid_o <= 1'b1;
          pc           <= pc + 32'd4;
          iss_cnt      <= '0;
          rcv_cnt      <= '0;
          state        <= FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch. Each test pushes the instructions
// it expects downstream to accept into a scoreboard queue; a monitor pops and
// compares on every accepted instruction. Port-timing checks are made inline.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_busy_i;
  logic [7:0]  mem_din_i;
  logic [31:0] mem_a_o;
  logic        mem_rd_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] mem [0:511];

  if_fetch #(.RESET_PC(32'h00000000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_busy_i      (mem_busy_i),
    .mem_din_i       (mem_din_i),
    .mem_a_o         (mem_a_o),
    .mem_rd_o        (mem_rd_o),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .inst_valid_o    (inst_valid_o)
  );

  always #5 clk = ~clk;

  // Memory returns the byte addressed in the previous cycle.
  always @(posedge clk) mem_din_i <= mem[mem_a_o[8:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    sb_q.push_back(e);
  endtask

  // Monitor: an instruction is accepted when valid and downstream not stalled.
  always @(negedge clk) begin
    if (!rst && !branch_flag_i && inst_valid_o && !stall_i) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_unexpected: got pc 0x%08h inst 0x%08h, expected none", pc_o, inst_o);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_pc", pc_o, mon_e.pc);
        check("sb_inst", inst_o, mon_e.inst);
      end
    end
  end

  // Two reset edges, checks of reset state, then leaves the bench in cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    stall_i = 1'b1;
    branch_flag_i = 1'b0;
    branch_target_i = '0;
    mem_busy_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_rd", {31'd0, mem_rd_o}, 32'd0);
    @(posedge clk); #1;
    check("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_addr", mem_a_o, 32'd0);
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'hC3;
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    mem[4] = 8'h93; mem[5] = 8'h05; mem[6] = 8'h20; mem[7] = 8'h00;
    mem[8] = 8'h63; mem[9] = 8'h04; mem[10] = 8'hB5; mem[11] = 8'h00;
    mem[9'h040] = 8'h13; mem[9'h041] = 8'h06; mem[9'h042] = 8'h30; mem[9'h043] = 8'h00;
    mem[9'h100] = 8'hEF; mem[9'h101] = 8'h00; mem[9'h102] = 8'hC0; mem[9'h103] = 8'h0F;
    mem_din_i = '0;

    // Test 1: back-to-back fetch, no stall or busy.
    do_reset();
    expect_word(32'h0, 32'h00100513);
    expect_word(32'h4, 32'h00200593);
    for (int c = 0; c <= 10; c++) begin
      stall_i = 1'b0;
      @(negedge clk);
      if (c < 4) begin
        check("t1_addr", mem_a_o, c);
        check("t1_rd", {31'd0, mem_rd_o}, 32'd1);
      end
      if (c == 4) begin
        check("t1_rd_c4", {31'd0, mem_rd_o}, 32'd0);
        check("t1_valid_c4", {31'd0, inst_valid_o}, 32'd0);
      end
      if (c == 5) begin
        check("t1_valid_c5", {31'd0, inst_valid_o}, 32'd1);
        check("t1_addr_c5", mem_a_o, 32'd4);
      end
      if (c == 10) check("t1_valid_c10", {31'd0, inst_valid_o}, 32'd1);
      next_cycle();
    end

    // Test 2: downstream stall from cycle 5, released in cycle 15.
    do_reset();
    expect_word(32'h0, 32'h00100513);
    expect_word(32'h4, 32'h00200593);
    expect_word(32'h8, 32'h00B50463);
    for (int c = 0; c <= 21; c++) begin
      stall_i = (c >= 5 && c < 15);
      @(negedge clk);
      if (c == 10 || c == 12) begin
        check("t2_hold_rd", {31'd0, mem_rd_o}, 32'd0);
        check("t2_hold_pc", pc_o, 32'd0);
      end
      if (c == 14) check("t2_hold_inst", inst_o, 32'h00100513);
      if (c == 16) begin
        check("t2_valid_c16", {31'd0, inst_valid_o}, 32'd1);
        check("t2_pc_c16", pc_o, 32'd4);
        check("t2_addr_c16", mem_a_o, 32'd8);
        check("t2_rd_c16", {31'd0, mem_rd_o}, 32'd1);
      end
      if (c == 21) check("t2_valid_c21", {31'd0, inst_valid_o}, 32'd1);
      next_cycle();
    end

    // Test 3: memory stage owns the port in cycle 2.
    do_reset();
    expect_word(32'h0, 32'h00100513);
    for (int c = 0; c <= 6; c++) begin
      stall_i = 1'b0;
      mem_busy_i = (c == 2);
      @(negedge clk);
      if (c == 2) check("t3_rd_c2", {31'd0, mem_rd_o}, 32'd0);
      if (c == 3) begin
        check("t3_addr_c3", mem_a_o, 32'd2);
        check("t3_rd_c3", {31'd0, mem_rd_o}, 32'd1);
      end
      if (c == 5) check("t3_valid_c5", {31'd0, inst_valid_o}, 32'd0);
      if (c == 6) check("t3_valid_c6", {31'd0, inst_valid_o}, 32'd1);
      next_cycle();
    end
    mem_busy_i = 1'b0;

    // Test 4: redirect to 0x100 in cycle 2.
    do_reset();
    expect_word(32'h100, 32'h0FC000EF);
    for (int c = 0; c <= 8; c++) begin
      stall_i = 1'b0;
      branch_flag_i = (c == 2);
      branch_target_i = (c == 2) ? 32'h100 : 32'h0;
      @(negedge clk);
      if (c == 2) check("t4_rd_c2", {31'd0, mem_rd_o}, 32'd0);
      if (c == 3) check("t4_addr_c3", mem_a_o, 32'h100);
      if (c == 6) check("t4_addr_c6", mem_a_o, 32'h103);
      if (c == 7) check("t4_valid_c7", {31'd0, inst_valid_o}, 32'd0);
      if (c == 8) check("t4_valid_c8", {31'd0, inst_valid_o}, 32'd1);
      next_cycle();
    end
    branch_flag_i = 1'b0;

    // Test 5: one-cycle reset in cycle 3 restarts the fetch.
    do_reset();
    expect_word(32'h0, 32'h00100513);
    for (int c = 0; c <= 9; c++) begin
      stall_i = 1'b0;
      rst = (c == 3);
      @(negedge clk);
      if (c == 3) check("t5_rd_rst", {31'd0, mem_rd_o}, 32'd0);
      if (c == 4) begin
        check("t5_valid_c4", {31'd0, inst_valid_o}, 32'd0);
        check("t5_pc_c4", pc_o, 32'd0);
        check("t5_inst_c4", inst_o, 32'd0);
        check("t5_addr_c4", mem_a_o, 32'd0);
      end
      if (c == 8) check("t5_valid_c8", {31'd0, inst_valid_o}, 32'd0);
      if (c == 9) check("t5_valid_c9", {31'd0, inst_valid_o}, 32'd1);
      next_cycle();
    end

    // Test 6: redirect to 0x40 on the completion edge discards the word.
    do_reset();
    expect_word(32'h40, 32'h00300613);
    for (int c = 0; c <= 10; c++) begin
      stall_i = 1'b0;
      branch_flag_i = (c == 4);
      branch_target_i = (c == 4) ? 32'h40 : 32'h0;
      @(negedge clk);
      if (c == 5) begin
        check("t6_valid_c5", {31'd0, inst_valid_o}, 32'd0);
        check("t6_addr_c5", mem_a_o, 32'h40);
        check("t6_rd_c5", {31'd0, mem_rd_o}, 32'd1);
      end
      if (c == 10) check("t6_valid_c10", {31'd0, inst_valid_o}, 32'd1);
      next_cycle();
    end
    branch_flag_i = 1'b0;

    check("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
